// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: drives a W-bit T flip-flop bank as a loadable up/down counter purely through toggle enables.
module tff_count_sequencer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         up_down,
    input  logic         reload,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic [W-1:0] t_vec,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, state_nx;
    logic up_l, reload_l, at_term;
    logic [W-1:0] limit_l, term, init, cnt_t;
    assign term = up_l ? limit_l : '0;
    assign init = up_l ? '0 : limit_l;
    assign at_term = q == term;
    assign busy = state != IDLE;
    assign cnt_t[0] = 1'b1;
    // a bit toggles when every lower bit is 1 (up) or 0 (down)
    for (genvar i = 1; i < W; i++) begin : g_cnt
        assign cnt_t[i] = up_l ? &q[i-1:0] : ~|q[i-1:0];
    end
    always_comb begin
        state_nx = state;
        t_vec = '0;
        case (state)
            IDLE: state_nx = start ? LOAD : IDLE;
            LOAD: begin
                state_nx = abort ? IDLE : RUN;
                t_vec = abort ? '0 : q ^ init;
            end
            RUN: begin
                state_nx = abort ? IDLE : at_term ? (reload_l ? LOAD : IDLE) : RUN;
                t_vec = (abort || at_term) ? '0 : cnt_t;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            done <= 1'b0;
            up_l <= 1'b0;
            reload_l <= 1'b0;
            limit_l <= '0;
        end else begin
            state <= state_nx;
            q <= q ^ t_vec;
            done <= state == RUN && !abort && at_term;
            if (state == IDLE && start) begin
                up_l <= up_down;
                reload_l <= reload;
                limit_l <= limit;
            end
        end
    end
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: directed and random stimulus against a schedule-based model of the counter runs.
module tb_tff_count_sequencer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst, start, abort, up_down, reload;
    logic [W-1:0] limit, q, t_vec;
    logic busy, done;
    int npass = 0, ntot = 0;
    int pq[$];
    int mq = 0, md = 0, ud_l = 0, rl_l = 0, lim_l = 0;

    tff_count_sequencer #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .up_down(up_down),
        .reload(reload), .limit(limit), .q(q), .t_vec(t_vec), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    endtask

    // a run is the LOAD cycle (showing the old q) followed by every value from init to term
    task automatic build(input int load_q);
        pq.push_back(load_q);
        for (int v = 0; v <= lim_l; v++) pq.push_back(ud_l != 0 ? v : lim_l - v);
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic ud,
                        input logic rl, input logic [W-1:0] lm);
        int nxt;
        logic eb;
        @(negedge clk);
        rst = r; start = s; abort = a; up_down = ud; reload = rl; limit = lm;
        #1;
        eb = pq.size() != 0;
        nxt = (eb && !a && pq.size() > 1) ? pq[1] : mq;
        chk("q", 32'(q), 32'(mq));
        chk("t_vec", 32'(t_vec), eb ? 32'((mq ^ nxt) & ((1 << W) - 1)) : 32'd0);
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(md));
        @(posedge clk);
        if (r) begin
            pq.delete(); mq = 0; md = 0; ud_l = 0; rl_l = 0; lim_l = 0;
        end else if (eb) begin
            md = 0;
            if (a) pq.delete();
            else if (pq.size() == 1) begin
                md = 1;
                pq.delete();
                if (rl_l != 0) build(mq);
            end else void'(pq.pop_front());
            mq = nxt;
        end else begin
            md = 0;
            if (s) begin
                ud_l = int'(ud); rl_l = int'(rl); lim_l = int'(lm);
                build(mq);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; up_down = 0; reload = 0; limit = '0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, '0);
        idle(2);
        step(0, 1, 0, 1, 0, 4'd5);
        idle(10);
        step(0, 1, 0, 0, 0, 4'd9);
        idle(14);
        step(0, 1, 0, 1, 1, 4'd3);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 4'd7);
        step(0, 0, 1, 0, 0, '0);
        idle(2);
        step(0, 1, 0, 1, 0, 4'd12);
        for (int i = 0; i < 20 && mq != 6; i++) idle(1);
        step(0, 0, 1, 0, 0, '0);
        idle(3);
        step(0, 1, 0, 1, 0, 4'd12);
        idle(16);
        step(0, 1, 0, 1, 0, 4'd0);
        idle(4);
        step(0, 1, 0, 1, 0, 4'd15);
        idle(19);
        step(0, 1, 0, 1, 0, 4'd10);
        for (int i = 0; i < 20 && mq != 4; i++) idle(1);
        step(1, 0, 0, 0, 0, '0);
        idle(2);
        repeat (1500)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 1'($urandom), 1'($urandom), W'($urandom));
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller that sequences a W-bit bank of T flip-flops as a programmable up/down counter.
- The bank state changes only through a per-bit toggle vector: every cycle, q <= q ^ t_vec.
- The FSM generates t_vec for three operations: idle hold, initial-value load (done by toggling) and counting.
- Provides start/abort control, a terminal-count done pulse and an optional auto-reload mode.

Parameters:
- W, 4, counter / T-flip-flop bank width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a count run. Sampled only in IDLE; ignored otherwise.
- abort  input  1  terminate the current run. Sampled in LOAD and RUN.
- up_down  input  1  direction: 1 = count up 0→limit, 0 = count down limit→0. Latched on accepted start.
- reload  input  1  1 = auto-restart after terminal count. Latched on accepted start.
- limit  input  W  terminal/initial value. Latched on accepted start.
- q  output  W  T-flip-flop bank state (registered).
- t_vec  output  W  toggle enables applied this cycle (combinational from state, q and latched config).
- busy  output  1  high in LOAD and RUN.
- done  output  1  registered one-cycle pulse when terminal count is reached.

Behaviour:
- Reset (rst=1 at a clock edge) sets: state=IDLE, q=0, done=0, latched config=0. busy is therefore 0 and t_vec is 0. rst has priority over every other input and takes effect mid-run the same way.
- Terminal value term: 0 if the latched direction is down, otherwise latched limit. Initial value init: 0 if up, otherwise latched limit.
- IDLE:
  - t_vec=0, so q holds.
  - On start=1: latch up_down, reload and limit; go to LOAD.
- LOAD:
  - t_vec = q ^ init, so q==init after this edge.
  - If abort=1: t_vec=0 instead, go to IDLE.
  - Otherwise go to RUN.
- RUN:
  - Priority 1, abort=1: t_vec=0, go to IDLE, no done.
  - Priority 2, q==term: t_vec=0; done=1 on the next cycle. Go to LOAD if the latched reload=1, else IDLE.
  - Priority 3, otherwise, count:
    - Up: t_vec[0]=1; t_vec[i]=&q[i-1:0].
    - Down: t_vec[0]=1; t_vec[i]=&(~q[i-1:0]).
- done is high exactly one cycle per terminal event. It is never asserted by abort or rst.
- Timing for start accepted at edge k:
  - LOAD occupies cycle k+1.
  - The first RUN cycle, k+2, shows q=init.
  - Terminal detected in cycle k+2+limit.
  - done is high in cycle k+3+limit.
- limit=0: the first RUN cycle already has q==term, so done follows with no counting.
- Reload period is limit+2 cycles: limit counting cycles, one terminal cycle, one LOAD cycle.
- q never exceeds limit (up) and never underflows (down); the counter does not wrap naturally past 2^W-1 within a run.
- start while busy is ignored, including in the same cycle as terminal count.
- Config input changes during a run have no effect until the next accepted start.

Test Plan:
- Reset, then up count: rst 2 cycles; start with up_down=1, reload=0, limit=5 → q steps 0,1,2,3,4,5 in cycles k+2..k+7; done=1 only in cycle k+8; busy falls at k+8; q holds 5 afterwards.
- Down count with load from nonzero: initial q=5; start with up_down=0, limit=9 → LOAD t_vec=0xC, q=9; then q counts 9..0; done pulses once; q holds 0. Check t_vec equals the bitwise toggle vector each cycle (e.g. q=8→t_vec=0xF).
- Reload: up, limit=3, reload=1 → repeated q sequence 0,1,2,3,(3 during LOAD),0,...; done pulses every 5 cycles; busy stays 1 throughout.
- Abort mid-run: up, limit=12, abort at q=6 → IDLE next cycle, q frozen at 6, no done; a subsequent start re-runs correctly from 0.
- Boundaries: limit=0 → done exactly 3 cycles after start. start asserted while busy → no effect. W=4 up with limit=15 → reaches 15 without wrap, t_vec=0xF on the 7→8 transition.
- rst mid-run: rst at q=4 → next cycle q=0, IDLE, done=0, busy=0.
